// File: rtl/ppfifo_pkg.sv
// Shared PPFIFO definitions: reader state encoding, default widths and the
// handshake timing constants shared by the PPFIFO, its generators and its readers.
package ppfifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned SIZE_WIDTH_DEF = 24;

    // Activate leads the first strobe by this many cycles; release holds activate low at least this long.
    localparam int unsigned ACT_TO_STB_CYCLES  = 1;
    localparam int unsigned RELEASE_MIN_CYCLES = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVATE,
        ST_READ,
        ST_RELEASE
    } rd_state_e;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready buffer with registered head; a push lands on the output
// the next cycle when empty, and pushes are dropped while full (callers gate on full_o).
module stream_skid_buffer
    import ppfifo_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH_DEF + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld_i,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             out_vld_o,
    output logic [WIDTH-1:0] out_dat_o,
    input  logic             out_rdy_i,
    output logic             full_o,
    output logic             empty_o
);

    logic             head_vld_q, head_vld_d;
    logic [WIDTH-1:0] head_dat_q, head_dat_d;
    logic             tail_vld_q, tail_vld_d;
    logic [WIDTH-1:0] tail_dat_q, tail_dat_d;
    logic             push;
    logic             pop;

    assign push = in_vld_i && !tail_vld_q;
    assign pop  = head_vld_q && out_rdy_i;

    always_comb begin
        head_vld_d = head_vld_q;
        head_dat_d = head_dat_q;
        tail_vld_d = tail_vld_q;
        tail_dat_d = tail_dat_q;
        if (pop) begin
            if (tail_vld_q) begin
                head_dat_d = tail_dat_q;
                tail_vld_d = push;
                if (push) tail_dat_d = in_dat_i;
            end else begin
                head_vld_d = push;
                if (push) head_dat_d = in_dat_i;
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_vld_d = 1'b1;
                head_dat_d = in_dat_i;
            end else begin
                tail_vld_d = 1'b1;
                tail_dat_d = in_dat_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_vld_q <= 1'b0;
            head_dat_q <= '0;
            tail_vld_q <= 1'b0;
            tail_dat_q <= '0;
        end else begin
            head_vld_q <= head_vld_d;
            head_dat_q <= head_dat_d;
            tail_vld_q <= tail_vld_d;
            tail_dat_q <= tail_dat_d;
        end
    end

    assign out_vld_o = head_vld_q;
    assign out_dat_o = head_dat_q;
    assign full_o    = tail_vld_q;
    assign empty_o   = !head_vld_q;

endmodule

// File: rtl/ppfifo_stream_reader.sv
// PPFIFO read master: claims a block, drains size words into a 2-deep skid and streams them with last.
// Strobe-to-output latency 1 cycle; strobes pause (independent of i_ready) while both skid slots hold data.
module ppfifo_stream_reader
    import ppfifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned SIZE_WIDTH = SIZE_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd_ready,
    output logic                  o_rd_activate,
    input  logic [SIZE_WIDTH-1:0] i_rd_size,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_rd_stb,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_last,
    input  logic                  i_ready,
    input  logic                  i_check_en,
    input  logic                  i_check_clear,
    output logic                  o_error,
    output logic [DATA_WIDTH-1:0] o_error_expected,
    output logic [DATA_WIDTH-1:0] o_error_actual,
    output logic [SIZE_WIDTH-1:0] o_total_count,
    output logic                  o_busy
);

    rd_state_e             state_q, state_d;
    logic                  act_q;
    logic                  busy_q;
    logic [SIZE_WIDTH-1:0] size_q;
    logic [SIZE_WIDTH-1:0] cnt_q;
    logic                  more;
    logic                  drain_done;
    logic                  hs;
    logic                  skid_full;
    logic                  skid_empty;
    logic [DATA_WIDTH:0]   skid_out;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] err_exp_q;
    logic [DATA_WIDTH-1:0] err_act_q;
    logic [SIZE_WIDTH-1:0] total_q;
    logic                  base_vld_q;
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] prev_inc;

    assign hs         = o_valid && i_ready;
    assign more       = cnt_q < size_q;
    assign o_rd_stb   = (state_q == ST_READ) && more && !skid_full;
    // Leave READ on the cycle the final word is handed off, so activate drops right after it.
    assign drain_done = !more && (skid_empty || (!skid_full && hs));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (i_rd_ready) state_d = ST_ACTIVATE;
            ST_ACTIVATE: state_d = (i_rd_size == '0) ? ST_RELEASE : ST_READ;
            ST_READ:     if (drain_done) state_d = ST_RELEASE;
            ST_RELEASE:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            act_q   <= 1'b0;
            busy_q  <= 1'b0;
            size_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            act_q   <= (state_d == ST_ACTIVATE) || (state_d == ST_READ);
            busy_q  <= (state_d != ST_IDLE);
            if (state_q == ST_ACTIVATE) begin
                size_q <= i_rd_size;
                cnt_q  <= '0;
            end else if (o_rd_stb) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    stream_skid_buffer #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_vld_i (o_rd_stb),
        .in_dat_i ({(cnt_q == size_q - 1'b1), i_rd_data}),
        .out_vld_o(o_valid),
        .out_dat_o(skid_out),
        .out_rdy_i(i_ready),
        .full_o   (skid_full),
        .empty_o  (skid_empty)
    );

    assign o_data = skid_out[DATA_WIDTH-1:0];
    assign o_last = skid_out[DATA_WIDTH];

    assign prev_inc = prev_q + 1'b1;

    // A clear coinciding with a handshake wins: count restarts at 0 and that word seeds the pattern.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
            total_q    <= '0;
            base_vld_q <= 1'b0;
            prev_q     <= '0;
        end else if (i_check_clear) begin
            err_q      <= 1'b0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
            total_q    <= '0;
            base_vld_q <= hs && i_check_en;
            if (hs && i_check_en) prev_q <= o_data;
        end else if (hs) begin
            total_q <= total_q + 1'b1;
            if (i_check_en) begin
                base_vld_q <= 1'b1;
                prev_q     <= o_data;
                if (base_vld_q && !err_q && (o_data != prev_inc)) begin
                    err_q     <= 1'b1;
                    err_exp_q <= prev_inc;
                    err_act_q <= o_data;
                end
            end
        end
    end

    assign o_rd_activate    = act_q;
    assign o_busy           = busy_q;
    assign o_error          = err_q;
    assign o_error_expected = err_exp_q;
    assign o_error_actual   = err_act_q;
    assign o_total_count    = total_q;

endmodule

// File: tb/tb_ppfifo_stream_reader.sv
// Randomized bench: a behavioural PPFIFO supplies queued blocks, a scoreboard checks the stream,
// and a word-level model of the checker/counter tracks the expected status outputs.
module tb_ppfifo_stream_reader;

    localparam int DW = 32;
    localparam int SW = 24;

    logic          clk;
    logic          rst;
    logic          i_rd_ready;
    logic          o_rd_activate;
    logic [SW-1:0] i_rd_size;
    logic [DW-1:0] i_rd_data;
    logic          o_rd_stb;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          o_last;
    logic          i_ready;
    logic          i_check_en;
    logic          i_check_clear;
    logic          o_error;
    logic [DW-1:0] o_error_expected;
    logic [DW-1:0] o_error_actual;
    logic [SW-1:0] o_total_count;
    logic          o_busy;

    ppfifo_stream_reader #(.DATA_WIDTH(DW), .SIZE_WIDTH(SW)) dut (
        .clk             (clk),
        .rst             (rst),
        .i_rd_ready      (i_rd_ready),
        .o_rd_activate   (o_rd_activate),
        .i_rd_size       (i_rd_size),
        .i_rd_data       (i_rd_data),
        .o_rd_stb        (o_rd_stb),
        .o_data          (o_data),
        .o_valid         (o_valid),
        .o_last          (o_last),
        .i_ready         (i_ready),
        .i_check_en      (i_check_en),
        .i_check_clear   (i_check_clear),
        .o_error         (o_error),
        .o_error_expected(o_error_expected),
        .o_error_actual  (o_error_actual),
        .o_total_count   (o_total_count),
        .o_busy          (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // FIFO-side state: pending block sizes, pending words, block being read
    int            sz_q[$];
    logic [DW-1:0] dq[$];
    logic [DW-1:0] exp_d[$];
    logic          exp_l[$];
    logic          cur_active = 1'b0;
    int            cur_size = 0;
    int            cur_idx = 0;
    int            rdy_mode = 0;
    int            rdy_ph = 0;
    logic          clr_pending = 1'b0;
    logic          clr_rand = 1'b0;

    // monitor state
    int   cyc = 0;
    logic stb_s = 1'b0;
    logic act_prev = 1'b0;
    logic first_stb = 1'b0;
    logic stall = 1'b0;
    logic [DW-1:0] stall_dat = '0;
    logic stall_last = 1'b0;
    int   stb_tot = 0, hs_tot = 0, n_act_rise = 0, act_cyc = 0, vld_cyc = 0;
    int   t_act = 0, t_fall = 0, t_stb0 = 0, t_stb_last = 0, t_hs_last = 0;

    // checker/counter reference
    int            m_total = 0;
    logic          m_err = 1'b0;
    logic          m_base = 1'b0;
    logic [DW-1:0] m_exp = '0, m_act = '0, m_prev = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_total = 0; m_err = 1'b0; m_base = 1'b0; m_exp = '0; m_act = '0; m_prev = '0;
    endtask

    task automatic model_word(input logic hs, input logic [DW-1:0] w, input logic clr, input logic en);
        logic [DW-1:0] want;
        if (clr) begin
            model_reset();
            if (hs && en) begin
                m_base = 1'b1;
                m_prev = w;
            end
        end else if (hs) begin
            m_total = m_total + 1;
            if (en) begin
                want = m_prev + 32'd1;
                if (m_base && !m_err && w != want) begin
                    m_err = 1'b1;
                    m_exp = want;
                    m_act = w;
                end
                m_base = 1'b1;
                m_prev = w;
            end
        end
    endtask

    // One clock: observe at the falling edge, then update FIFO-side inputs just after the rising edge.
    task automatic tick();
        logic hs;
        logic [DW-1:0] ed;
        logic el;
        @(negedge clk);
        cyc++;
        if (rst) begin
            stb_tot = 0; hs_tot = 0; stall = 1'b0; act_prev = 1'b0; stb_s = 1'b0;
            model_reset();
        end else begin
            stb_s = o_rd_stb;
            hs    = o_valid && i_ready;
            if (stall) begin
                check_eq("stall_vld", o_valid, 1);
                check_eq("stall_dat", o_data, stall_dat);
                check_eq("stall_last", o_last, stall_last);
            end
            stall = o_valid && !i_ready; stall_dat = o_data; stall_last = o_last;
            if (o_rd_activate && !act_prev) begin t_act = cyc; n_act_rise++; first_stb = 1'b1; end
            if (!o_rd_activate && act_prev) t_fall = cyc;
            if (o_rd_activate) act_cyc++;
            if (o_valid) vld_cyc++;
            act_prev = o_rd_activate;
            if (stb_s) begin
                check_eq("stb_in_block", cur_active && (cur_idx < cur_size), 1);
                if (first_stb) begin t_stb0 = cyc; first_stb = 1'b0; end
                t_stb_last = cyc;
                stb_tot++;
            end
            if (hs) begin
                hs_tot++;
                t_hs_last = cyc;
                check_eq("hs_expected", exp_d.size() != 0, 1);
                if (exp_d.size() != 0) begin
                    ed = exp_d.pop_front();
                    el = exp_l.pop_front();
                    check_eq("out_data", o_data, ed);
                    check_eq("out_last", o_last, el);
                end
            end
            if (stb_s || hs) check_eq("outstanding_le2", (stb_tot - hs_tot) <= 2, 1);
            model_word(hs, o_data, i_check_clear, i_check_en);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            cur_active = 1'b0;
            i_rd_ready = 1'b0;
            i_check_clear = 1'b0;
        end else begin
            if (stb_s && cur_active) begin
                cur_idx++;
                if (dq.size() != 0) void'(dq.pop_front());
            end
            if (cur_active && !o_rd_activate) begin
                check_eq("words_taken", cur_idx, cur_size);
                cur_active = 1'b0;
            end else if (!cur_active && o_rd_activate) begin
                check_eq("act_has_block", sz_q.size() != 0, 1);
                if (sz_q.size() != 0) begin
                    cur_size = sz_q.pop_front();
                    cur_idx = 0;
                    cur_active = 1'b1;
                end
            end
            i_rd_ready = (sz_q.size() != 0) && !cur_active && !o_rd_activate;
            i_rd_size  = cur_active ? SW'(cur_size) : SW'($urandom);
            i_rd_data  = (cur_active && cur_idx < cur_size && dq.size() != 0) ? dq[0] : $urandom;
            rdy_ph++;
            case (rdy_mode)
                0:       i_ready = 1'b1;
                1:       i_ready = (rdy_ph % 3) == 0;
                default: i_ready = ($urandom_range(0, 9) < 6);
            endcase
            i_check_clear = clr_pending || (clr_rand && $urandom_range(0, 24) == 0);
            clr_pending = 1'b0;
        end
    endtask

    // Words are base+i, bumped by one from index skip_at onwards to inject a pattern break.
    task automatic push_blk(input int n, input logic [DW-1:0] base, input int skip_at);
        logic [DW-1:0] w;
        sz_q.push_back(n);
        for (int i = 0; i < n; i++) begin
            w = base + DW'(i) + ((i >= skip_at) ? 32'd1 : 32'd0);
            dq.push_back(w);
            exp_d.push_back(w);
            exp_l.push_back(i == n - 1);
        end
    endtask

    task automatic wait_idle(input int bound);
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < bound && !idle; i++) begin
            tick();
            idle = (sz_q.size() == 0) && !cur_active && !o_busy && (exp_d.size() == 0) && !o_rd_activate;
        end
        check_eq("idle_in_time", idle, 1);
        repeat (2) tick();
    endtask

    task automatic check_model(input string tag);
        check_eq({tag, "_total"}, o_total_count, SW'(m_total));
        check_eq({tag, "_err"}, o_error, m_err);
        check_eq({tag, "_exp"}, o_error_expected, m_exp);
        check_eq({tag, "_act"}, o_error_actual, m_act);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_act"}, o_rd_activate, 0);
        check_eq({tag, "_stb"}, o_rd_stb, 0);
        check_eq({tag, "_vld"}, o_valid, 0);
        check_eq({tag, "_last"}, o_last, 0);
        check_eq({tag, "_data"}, o_data, 0);
        check_eq({tag, "_err"}, o_error, 0);
        check_eq({tag, "_eexp"}, o_error_expected, 0);
        check_eq({tag, "_eact"}, o_error_actual, 0);
        check_eq({tag, "_total"}, o_total_count, 0);
        check_eq({tag, "_busy"}, o_busy, 0);
    endtask

    initial begin : main
        int s_stb, s_vld, s_act, s_rise, h0, n, skip;
        logic [DW-1:0] base;
        rst = 1'b1;
        i_rd_ready = 1'b0; i_rd_size = '0; i_rd_data = '0;
        i_ready = 1'b0; i_check_en = 1'b0; i_check_clear = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) tick();

        // 4 words at full rate
        s_stb = stb_tot;
        push_blk(4, 32'd0, 4);
        wait_idle(100);
        check_eq("b4_stb_count", stb_tot - s_stb, 4);
        check_eq("b4_act_to_stb", t_stb0 - t_act, 1);
        check_eq("b4_stb_span", t_stb_last - t_stb0, 3);
        check_eq("b4_hs_to_fall", t_fall - t_hs_last, 1);
        check_eq("b4_total", o_total_count, 4);
        check_model("b4");

        // zero-size block
        s_stb = stb_tot; s_vld = vld_cyc; s_act = act_cyc; s_rise = n_act_rise;
        push_blk(0, 32'd0, 0);
        wait_idle(100);
        check_eq("z_stb", stb_tot - s_stb, 0);
        check_eq("z_vld", vld_cyc - s_vld, 0);
        check_eq("z_act_cycles", act_cyc - s_act, 1);
        check_eq("z_act_rises", n_act_rise - s_rise, 1);
        check_eq("z_busy", o_busy, 0);

        // 8 words with ready pattern 1,0,0
        rdy_mode = 1;
        push_blk(8, 32'd0, 8);
        wait_idle(200);
        check_eq("b8_total", o_total_count, 12);
        rdy_mode = 0;

        // pattern checker: 5,6,8,9
        i_check_en = 1'b1;
        clr_pending = 1'b1;
        repeat (3) tick();
        check_eq("clr_total", o_total_count, 0);
        push_blk(4, 32'd5, 2);
        wait_idle(100);
        check_eq("pat_err", o_error, 1);
        check_eq("pat_exp", o_error_expected, 7);
        check_eq("pat_act", o_error_actual, 8);
        check_model("pat");

        // back-to-back blocks of 3
        clr_pending = 1'b1;
        repeat (3) tick();
        check_eq("clr_err", o_error, 0);
        s_rise = n_act_rise;
        push_blk(3, 32'd0, 3);
        push_blk(3, 32'd3, 3);
        wait_idle(200);
        check_eq("b2b_rises", n_act_rise - s_rise, 2);
        check_eq("b2b_total", o_total_count, 6);
        check_eq("b2b_err", o_error, 0);
        check_model("b2b");

        // reset after 2 of 6 words
        h0 = hs_tot;
        push_blk(6, 32'd20, 6);
        for (int i = 0; i < 100 && (hs_tot - h0) < 2; i++) tick();
        check_eq("rst_two_words", (hs_tot - h0) >= 2, 1);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("midrst");
        sz_q.delete(); dq.delete(); exp_d.delete(); exp_l.delete();
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        push_blk(4, 32'd100, 4);
        wait_idle(100);
        check_eq("post_rst_total", o_total_count, 4);
        check_model("post_rst");

        // randomized blocks, ready, clears and checker enable
        rdy_mode = 2;
        clr_rand = 1'b1;
        for (int b = 0; b < 14; b++) begin
            i_check_en = ($urandom_range(0, 3) != 0);
            n = $urandom_range(1, 9);
            base = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFFC : $urandom;
            skip = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : n;
            push_blk(n, base, skip);
            wait_idle(400);
            check_model("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
